// File: rtl/ftoi_pipe.sv
// Three-stage IEEE-754 single to signed int32 converter, round-half-away-from-zero, saturating.
// Optional FTOI_INVALID_EN adds out_invalid (NaN, Inf or saturated result).
module ftoi_pipe #(
   parameter int LATENCY = 3
) (
   input  logic        clk,
   input  logic        rstn,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [31:0] in_data,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_data
`ifdef FTOI_INVALID_EN
   ,
   output logic        out_invalid
`endif
);

   generate
      if (LATENCY != 3) begin : g_bad_latency
         $error("ftoi_pipe: LATENCY must be 3");
      end
   endgenerate

   logic        en;

   // Stage 1: unpack and classify
   logic        v1_q;
   logic        s1_q;
   logic [7:0]  e1_q;
   logic [23:0] mant1_q;
   logic        zero1_q, ovf1_q;
   logic [7:0]  e_in;
   logic        zero1_d, ovf1_d;

   // Stage 2: aligned magnitude plus round bit
   logic        v2_q;
   logic        s2_q, zero2_q, ovf2_q, rnd2_q;
   logic [32:0] mag2_q;
   logic [32:0] mag2_d;
   logic        rnd2_d;
   logic [7:0]  lsh, rsh;

   // Stage 3: output register
   logic        v3_q;
   logic [31:0] out_data_q;
   logic [31:0] out_data_d;
   logic [32:0] r3;

`ifdef FTOI_INVALID_EN
   logic        inv1_q, inv2_q, inv3_q;
   logic        inv1_d, inv3_d;
`endif

   assign en        = !(v3_q && !out_ready);
   assign in_ready  = en;
   assign out_valid = v3_q;
   assign out_data  = out_data_q;

   assign e_in    = in_data[30:23];
   assign zero1_d = (e_in < 8'd126);
   assign ovf1_d  = (e_in >= 8'd158);

`ifdef FTOI_INVALID_EN
   // -2^31 lands in the overflow band but is exactly representable.
   assign inv1_d      = ovf1_d && !(in_data[31] && e_in == 8'd158 && in_data[22:0] == 23'd0);
   assign out_invalid = inv3_q;
`endif

   always_comb begin
      lsh    = e1_q - 8'd150;
      rsh    = 8'd150 - e1_q;
      mag2_d = 33'd0;
      rnd2_d = 1'b0;
      if (e1_q >= 8'd150) begin
         mag2_d = {9'd0, mant1_q} << lsh;
      end else begin
         mag2_d = {9'd0, mant1_q} >> rsh;
         rnd2_d = |(mant1_q & (24'd1 << (rsh - 8'd1)));
      end
   end

   always_comb begin
      r3         = mag2_q + {32'd0, rnd2_q};
      out_data_d = 32'd0;
`ifdef FTOI_INVALID_EN
      inv3_d     = inv2_q;
`endif
      if (zero2_q) begin
         out_data_d = 32'd0;
      end else if (!s2_q) begin
         if (ovf2_q || r3 > 33'h0_7FFF_FFFF) begin
            out_data_d = 32'h7FFF_FFFF;
`ifdef FTOI_INVALID_EN
            inv3_d     = 1'b1;
`endif
         end else begin
            out_data_d = r3[31:0];
         end
      end else begin
         if (ovf2_q || r3 > 33'h0_8000_0000) begin
            out_data_d = 32'h8000_0000;
`ifdef FTOI_INVALID_EN
            inv3_d     = inv2_q || (r3 > 33'h0_8000_0000);
`endif
         end else begin
            out_data_d = ~r3[31:0] + 32'd1;
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         v1_q       <= 1'b0;
         s1_q       <= 1'b0;
         e1_q       <= 8'd0;
         mant1_q    <= 24'd0;
         zero1_q    <= 1'b0;
         ovf1_q     <= 1'b0;
         v2_q       <= 1'b0;
         s2_q       <= 1'b0;
         zero2_q    <= 1'b0;
         ovf2_q     <= 1'b0;
         rnd2_q     <= 1'b0;
         mag2_q     <= 33'd0;
         v3_q       <= 1'b0;
         out_data_q <= 32'd0;
`ifdef FTOI_INVALID_EN
         inv1_q     <= 1'b0;
         inv2_q     <= 1'b0;
         inv3_q     <= 1'b0;
`endif
      end else if (en) begin
         v1_q       <= in_valid;
         s1_q       <= in_data[31];
         e1_q       <= e_in;
         mant1_q    <= {1'b1, in_data[22:0]};
         zero1_q    <= zero1_d;
         ovf1_q     <= ovf1_d;
         v2_q       <= v1_q;
         s2_q       <= s1_q;
         zero2_q    <= zero1_q;
         ovf2_q     <= ovf1_q;
         rnd2_q     <= rnd2_d;
         mag2_q     <= mag2_d;
         v3_q       <= v2_q;
         out_data_q <= out_data_d;
`ifdef FTOI_INVALID_EN
         inv1_q     <= inv1_d;
         inv2_q     <= inv1_q;
         inv3_q     <= inv3_d;
`endif
      end
   end

endmodule

// File: tb/tb_ftoi_pipe.sv
// Self-checking bench for ftoi_pipe: directed vectors, backpressure, async reset, random stream
// against a real-arithmetic reference model.
module tb_ftoi_pipe;

   logic        clk = 1'b0;
   logic        rstn;
   logic        in_valid;
   logic        in_ready;
   logic [31:0] in_data;
   logic        out_valid;
   logic        out_ready;
   logic [31:0] out_data;
`ifdef FTOI_INVALID_EN
   logic        out_invalid;
`endif

   always #5 clk = ~clk;

   ftoi_pipe #(.LATENCY(3)) dut (
      .clk       (clk),
      .rstn      (rstn),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .in_data   (in_data),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .out_data  (out_data)
`ifdef FTOI_INVALID_EN
      ,
      .out_invalid (out_invalid)
`endif
   );

   typedef struct {
      logic [31:0] data;
      logic        inv;
      int          cyc;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] got_q[$];
   logic        got_inv_q[$];
   int          n_checks = 0;
   int          n_fail   = 0;
   int          cyc      = 0;
   int          n_out    = 0;
   logic        check_lat = 1'b0;
   logic        hold_prev = 1'b0;
   logic [31:0] prev_data = 32'd0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // Reference: value = 1.m * 2^(e-127), rounded half away from zero, then saturated.
   function automatic logic [32:0] model(input logic [31:0] f);
      logic        s;
      int          e;
      real         a, r;
      longint      ri;
      logic [31:0] res;
      s = f[31];
      e = int'(f[30:23]);
      if (e == 255) return {1'b1, (s ? 32'h8000_0000 : 32'h7FFF_FFFF)};
      if (e == 0) return 33'd0;
      a = real'(int'({1'b1, f[22:0]}));
      if (e >= 150) for (int i = 0; i < e - 150; i++) a = a * 2.0;
      else          for (int i = 0; i < 150 - e; i++) a = a / 2.0;
      r = $floor(a + 0.5);
      if (!s) begin
         if (r > 2147483647.0) return {1'b1, 32'h7FFF_FFFF};
         ri = longint'(r);
         return {1'b0, ri[31:0]};
      end
      if (r > 2147483648.0) return {1'b1, 32'h8000_0000};
      ri  = -longint'(r);
      res = ri[31:0];
      return {1'b0, res};
   endfunction

   // Monitor: sample at negedge, transfers happen at the following posedge.
   always @(negedge clk) begin
      if (!rstn) begin
         exp_q.delete();
         hold_prev = 1'b0;
      end else begin
         exp_t        e;
         logic [32:0] m;
         cyc++;
         if (hold_prev) begin
            check_eq("hold_valid", {31'd0, out_valid}, 32'd1);
            check_eq("hold_data", out_data, prev_data);
         end
         if (out_valid && out_ready) begin
            n_out++;
            $display("out #%0d data=%h", n_out, out_data);
            got_q.push_back(out_data);
`ifdef FTOI_INVALID_EN
            got_inv_q.push_back(out_invalid);
`endif
            if (exp_q.size() == 0) begin
               check_eq("unexpected_out", out_data, 32'hxxxx_xxxx);
            end else begin
               e = exp_q.pop_front();
               check_eq("data", out_data, e.data);
`ifdef FTOI_INVALID_EN
               check_eq("invalid", {31'd0, out_invalid}, {31'd0, e.inv});
`endif
               if (check_lat) check_eq("latency", cyc - e.cyc, 32'd3);
            end
         end
         if (in_valid && in_ready) begin
            m      = model(in_data);
            e.data = m[31:0];
            e.inv  = m[32];
            e.cyc  = cyc;
            exp_q.push_back(e);
         end
         hold_prev = out_valid && !out_ready;
         prev_data = out_data;
      end
   end

   task automatic send(input logic [31:0] f);
      logic acc;
      acc      = 1'b0;
      in_valid = 1'b1;
      in_data  = f;
      for (int t = 0; t < 100 && !acc; t++) begin
         @(negedge clk);
         acc = in_ready;
         @(posedge clk);
         #1;
      end
      if (!acc) check_eq("send_timeout", 32'd0, 32'd1);
   endtask

   task automatic drain();
      for (int c = 0; c < 60 && exp_q.size() > 0; c++) begin
         @(posedge clk);
         #1;
      end
      check_eq("drain_empty", exp_q.size(), 32'd0);
   endtask

   task automatic check_log(input string tag, input int idx, input logic [31:0] exp);
      logic [31:0] got;
      got = (idx < got_q.size()) ? got_q[idx] : 32'hxxxx_xxxx;
      check_eq(tag, got, exp);
   endtask

   logic [31:0] s1_vec [3] = '{32'h3F80_0000, 32'h4020_0000, 32'hC020_0000};
   logic [31:0] s1_exp [3] = '{32'd1, 32'd3, 32'hFFFF_FFFD};
   logic [31:0] d_vec  [8] = '{32'h3ECC_CCCD, 32'h3F00_0000, 32'h8000_0000, 32'h0040_0000,
                              32'h4F32_D05E, 32'hCF00_0000, 32'h7F80_0000, 32'hFF80_0000};
   logic [31:0] d_exp  [8] = '{32'd0, 32'd1, 32'd0, 32'd0,
                              32'h7FFF_FFFF, 32'h8000_0000, 32'h7FFF_FFFF, 32'h8000_0000};
   logic        d_inv  [8] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
   logic [31:0] bp_vec [5] = '{32'h4120_0000, 32'hC2F6_0000, 32'h4B00_0001, 32'h3FC0_0000, 32'hBFC0_0000};

   initial begin
      int          base, k, stall, n;
      logic        seen;
      logic [31:0] f;

      rstn      = 1'b0;
      in_valid  = 1'b0;
      in_data   = 32'd0;
      out_ready = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      check_eq("rst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("rst_out_data", out_data, 32'd0);
      @(posedge clk);
      #1 rstn = 1'b1;
      #1 check_eq("rst_in_ready", {31'd0, in_ready}, 32'd1);

      // Back-to-back stream with no stall
      check_lat = 1'b1;
      base = got_q.size();
      foreach (s1_vec[i]) send(s1_vec[i]);
      in_valid = 1'b0;
      drain();
      foreach (s1_exp[i]) check_log("stream", base + i, s1_exp[i]);

      // Rounding boundaries and saturation
      base = got_q.size();
      foreach (d_vec[i]) send(d_vec[i]);
      in_valid = 1'b0;
      drain();
      foreach (d_exp[i]) check_log("directed", base + i, d_exp[i]);
`ifdef FTOI_INVALID_EN
      foreach (d_inv[i]) check_eq("directed_inv",
         {31'd0, (base + i < got_inv_q.size()) ? got_inv_q[base + i] : 1'bx}, {31'd0, d_inv[i]});
`endif

      // Backpressure: 4 stalled cycles from the first out_valid
      check_lat = 1'b0;
      k = 0; stall = 0; seen = 1'b0;
      for (int c = 0; c < 40 && (k < 5 || exp_q.size() > 0); c++) begin
         in_valid = (k < 5);
         in_data  = (k < 5) ? bp_vec[k] : 32'd0;
         if (out_valid) seen = 1'b1;
         if (seen && stall < 4) begin
            out_ready = 1'b0;
            stall++;
         end else begin
            out_ready = 1'b1;
         end
         @(negedge clk);
         if (!out_ready) check_eq("bp_in_ready", {31'd0, in_ready}, 32'd0);
         if (in_valid && in_ready) k++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("bp_accepted", k, 32'd5);
      drain();

      // Asynchronous reset with a full pipe
      out_ready = 1'b0;
      foreach (s1_vec[i]) send(s1_vec[i]);
      in_valid = 1'b0;
      #1 rstn = 1'b0;
      #1;
      check_eq("arst_out_valid", {31'd0, out_valid}, 32'd0);
      check_eq("arst_out_data", out_data, 32'd0);
      @(posedge clk);
      #1 rstn  = 1'b1;
      out_ready = 1'b1;
      check_lat = 1'b1;
      base = got_q.size();
      send(32'h4120_0000);
      in_valid = 1'b0;
      drain();
      check_log("post_reset", base, 32'd10);
      check_eq("post_reset_count", got_q.size() - base, 32'd1);

      // Random stream with random backpressure
      check_lat = 1'b0;
      n = 0;
      for (int c = 0; c < 60000 && n < 10000; c++) begin
         f = $urandom;
         if ($urandom_range(0, 1) == 1) f[30:23] = 8'($urandom_range(120, 160));
         in_valid  = ($urandom_range(0, 3) != 0);
         in_data   = f;
         out_ready = ($urandom_range(0, 2) != 0);
         @(negedge clk);
         if (in_valid && in_ready) n++;
         @(posedge clk);
         #1;
      end
      in_valid  = 1'b0;
      out_ready = 1'b1;
      check_eq("rand_count", n, 32'd10000);
      drain();

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
